// File: rtl/sd_pkg.sv
// sd_pkg: shared command bytes, CRCs, R1 codes and state/error encodings for the SD init sequencer.
// SD_CMD58_EN adds the CMD58 (OCR read) state to the main FSM encoding.
package sd_pkg;
  localparam logic [7:0] CMD0   = 8'h40;
  localparam logic [7:0] CMD8   = 8'h48;
  localparam logic [7:0] CMD17  = 8'h51;
  localparam logic [7:0] CMD55  = 8'h77;
  localparam logic [7:0] ACMD41 = 8'h69;
  localparam logic [7:0] CMD58  = 8'h7A;
  localparam logic [7:0] CRC_CMD0 = 8'h95;
  localparam logic [7:0] CRC_CMD8 = 8'h87;
  localparam logic [7:0] CRC_NONE = 8'hFF;
  localparam logic [31:0] ARG_CMD8   = 32'h0000_01AA;
  localparam logic [31:0] ARG_ACMD41 = 32'h4000_0000;
  localparam logic [7:0] R1_READY = 8'h00;
  localparam logic [7:0] R1_IDLE  = 8'h01;
  // idle + illegal command: a v1 card rejecting CMD8
  localparam logic [7:0] R1_V1    = 8'h05;
  typedef enum logic [3:0] {
    ERR_NONE    = 4'd0,
    ERR_CMD0    = 4'd1,
    ERR_CMD8    = 4'd2,
    ERR_ACMD41  = 4'd3,
    ERR_CMD17   = 4'd4,
    ERR_TIMEOUT = 4'd5,
    ERR_CMD58   = 4'd6
  } err_e;
  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD0,
    S_CMD8,
    S_CMD55,
    S_ACMD41,
    S_READY,
    S_CMD17,
    S_ERROR
`ifdef SD_CMD58_EN
    , S_CMD58
`endif
  } state_e;
  typedef enum logic [2:0] {
    I_IDLE,
    I_ISSUE,
    I_WAIT_BUSY,
    I_WAIT_DONE,
    I_CHECK
  } issue_e;
endpackage

// File: rtl/sd_cmd_issue.sv
// sd_cmd_issue: one engine command handshake (start pulse, busy/done wait, timeout),
// reporting a done pulse in the check cycle or a timeout pulse to the main sequencer.
module sd_cmd_issue
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic i_cmd_done,
  output logic o_cmd_start,
  output logic o_busy,
  output logic o_done,
  output logic o_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  issue_e r_state, w_next;
  logic [TW-1:0] r_tmo;
  logic w_hit, w_wait;
  assign w_wait = r_state == I_WAIT_BUSY || r_state == I_WAIT_DONE;
  assign w_hit  = r_tmo == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= I_IDLE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      r_tmo   <= w_wait ? r_tmo + 1'b1 : '0;
    end
  end
  always_comb begin
    w_next = I_IDLE;
    case (r_state)
      I_IDLE:      w_next = i_req ? I_ISSUE : I_IDLE;
      I_ISSUE:     w_next = I_WAIT_BUSY;
      I_WAIT_BUSY: w_next = !i_cmd_done ? I_WAIT_DONE : w_hit ? I_IDLE : I_WAIT_BUSY;
      I_WAIT_DONE: w_next = i_cmd_done ? I_CHECK : w_hit ? I_IDLE : I_WAIT_DONE;
      default:     w_next = I_IDLE;
    endcase
  end
  always_comb begin
    o_cmd_start = r_state == I_ISSUE;
    o_busy      = r_state != I_IDLE;
    o_done      = r_state == I_CHECK;
    o_timeout   = w_hit && ((r_state == I_WAIT_BUSY && i_cmd_done) ||
                            (r_state == I_WAIT_DONE && !i_cmd_done));
  end
endmodule

// File: rtl/sd_init_ctrl.sv
// sd_init_ctrl: SPI-mode SD power-up sequencer (CMD0, CMD8, CMD55/ACMD41) and CMD17 read server.
// Define SD_CMD58_EN to read the OCR after init and use byte addressing for SDSC cards.
module sd_init_ctrl
  import sd_pkg::*;
#(
  parameter int ACMD41_RETRIES = 1000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_init_req,
  output logic        o_init_done,
  output logic        o_init_err,
  output logic [3:0]  o_err_code,
  output logic        o_busy,
  input  logic        i_rd_req,
  input  logic [31:0] i_rd_addr,
  output logic        o_rd_ack,
  output logic [31:0] o_rd_data,
  output logic [7:0]  o_cmd_number,
  output logic [31:0] o_cmd_args,
  output logic [7:0]  o_cmd_crc,
  output logic        o_cmd_start,
  input  logic        i_cmd_done,
  input  logic [7:0]  i_cmd_resp_flags,
  input  logic [31:0] i_cmd_resp_data
);
  localparam int RW = $clog2(ACMD41_RETRIES + 1);
`ifdef SD_CMD58_EN
  localparam state_e S_POST_INIT = S_CMD58;
`else
  localparam state_e S_POST_INIT = S_READY;
`endif
  state_e r_state, w_next, w_goto;
  err_e r_err, w_err, w_code;
  logic [RW-1:0] r_retry;
  logic [31:0] r_addr, r_rd_data, w_rd_args;
  logic r_rd_ack, w_req, w_done, w_tmo, w_ok, w_last;
  assign w_req  = !(r_state inside {S_IDLE, S_READY, S_ERROR});
  assign w_last = r_retry == RW'(ACMD41_RETRIES - 1);
`ifdef SD_CMD58_EN
  logic r_ccs;
  assign w_rd_args = r_ccs ? r_addr : {r_addr[22:0], 9'd0};
`else
  assign w_rd_args = r_addr;
`endif
  sd_cmd_issue #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_issue (
    .clk         (clk),
    .reset       (reset),
    .i_req       (w_req),
    .i_cmd_done  (i_cmd_done),
    .o_cmd_start (o_cmd_start),
    .o_busy      (o_busy),
    .o_done      (w_done),
    .o_timeout   (w_tmo)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_err     <= ERR_NONE;
      r_retry   <= '0;
      r_addr    <= '0;
      r_rd_data <= '0;
      r_rd_ack  <= 1'b0;
`ifdef SD_CMD58_EN
      r_ccs     <= 1'b0;
`endif
    end else begin
      r_state  <= w_next;
      r_err    <= w_err;
      r_retry  <= (w_next == S_CMD0 && r_state != S_CMD0) ? '0 :
                  (r_state == S_ACMD41 && w_done && i_cmd_resp_flags == R1_IDLE) ? r_retry + 1'b1 : r_retry;
      r_rd_ack <= r_state == S_CMD17 && w_done && i_cmd_resp_flags == R1_READY;
      if (r_state == S_READY && i_rd_req && !i_init_req) r_addr <= i_rd_addr;
      if (r_state == S_CMD17 && w_done && i_cmd_resp_flags == R1_READY) r_rd_data <= i_cmd_resp_data;
`ifdef SD_CMD58_EN
      if (r_state == S_CMD58 && w_done && i_cmd_resp_flags == R1_READY) r_ccs <= i_cmd_resp_data[30];
`endif
    end
  end
  // per-command verdict on the R1 byte; w_goto is the next step on success
  always_comb begin
    w_ok   = 1'b0;
    w_goto = S_IDLE;
    w_code = ERR_NONE;
    case (r_state)
      S_CMD0:   begin w_ok = i_cmd_resp_flags == R1_IDLE; w_goto = S_CMD8; w_code = ERR_CMD0; end
      S_CMD8:   begin w_ok = i_cmd_resp_flags inside {R1_IDLE, R1_V1}; w_goto = S_CMD55; w_code = ERR_CMD8; end
      S_CMD55:  begin w_ok = i_cmd_resp_flags inside {R1_READY, R1_IDLE}; w_goto = S_ACMD41; w_code = ERR_ACMD41; end
      S_ACMD41: begin
        w_ok   = i_cmd_resp_flags == R1_READY || (i_cmd_resp_flags == R1_IDLE && !w_last);
        w_goto = i_cmd_resp_flags == R1_READY ? S_POST_INIT : S_CMD55;
        w_code = ERR_ACMD41;
      end
`ifdef SD_CMD58_EN
      S_CMD58:  begin w_ok = i_cmd_resp_flags == R1_READY; w_goto = S_READY; w_code = ERR_CMD58; end
`endif
      S_CMD17:  begin w_ok = i_cmd_resp_flags == R1_READY; w_goto = S_READY; w_code = ERR_CMD17; end
      default:  ;
    endcase
    case (r_state)
      S_IDLE:  w_next = i_init_req ? S_CMD0 : S_IDLE;
      S_READY: w_next = i_init_req ? S_CMD0 : i_rd_req ? S_CMD17 : S_READY;
      S_ERROR: w_next = i_init_req ? S_CMD0 : S_ERROR;
      default: w_next = w_tmo ? S_ERROR : !w_done ? r_state : w_ok ? w_goto : S_ERROR;
    endcase
    w_err = (r_state == S_ERROR && i_init_req) ? ERR_NONE :
            w_tmo ? ERR_TIMEOUT : (w_done && !w_ok) ? w_code : r_err;
  end
  always_comb begin
    o_cmd_number = 8'h00;
    o_cmd_args   = 32'h0;
    o_cmd_crc    = 8'h00;
    case (r_state)
      S_CMD0:   begin o_cmd_number = CMD0;   o_cmd_crc = CRC_CMD0; end
      S_CMD8:   begin o_cmd_number = CMD8;   o_cmd_args = ARG_CMD8;   o_cmd_crc = CRC_CMD8; end
      S_CMD55:  begin o_cmd_number = CMD55;  o_cmd_crc = CRC_NONE; end
      S_ACMD41: begin o_cmd_number = ACMD41; o_cmd_args = ARG_ACMD41; o_cmd_crc = CRC_NONE; end
`ifdef SD_CMD58_EN
      S_CMD58:  begin o_cmd_number = CMD58;  o_cmd_crc = CRC_NONE; end
`endif
      S_CMD17:  begin o_cmd_number = CMD17;  o_cmd_args = w_rd_args;  o_cmd_crc = CRC_NONE; end
      default:  ;
    endcase
    o_init_done = r_state == S_READY;
    o_init_err  = r_state == S_ERROR;
    o_err_code  = r_err;
    o_rd_ack    = r_rd_ack;
    o_rd_data   = r_rd_data;
  end
endmodule

// File: tb/tb_sd_init_ctrl.sv
// tb_sd_init_ctrl: directed bench for sd_init_ctrl with a scripted command-engine model
// (ACMD41_RETRIES=3, TIMEOUT_CYCLES=100); honours SD_CMD58_EN when defined.
module tb_sd_init_ctrl;
`ifdef SD_CMD58_EN
  localparam int N_INIT = 7;
  localparam logic [31:0] EXP_RD_ARG = 32'h0000_2000;
`else
  localparam int N_INIT = 6;
  localparam logic [31:0] EXP_RD_ARG = 32'h0000_0010;
`endif
  logic clk = 1'b0, reset = 1'b0, init_req = 1'b0, rd_req = 1'b0;
  logic [31:0] rd_addr = 32'h0;
  logic o_init_done, o_init_err, o_busy, o_rd_ack, o_cmd_start;
  logic [3:0] o_err_code;
  logic [31:0] o_rd_data, o_cmd_args;
  logic [7:0] o_cmd_number, o_cmd_crc;
  logic eng_done = 1'b1, hang = 1'b0;
  logic [7:0] eng_flags = 8'h00;
  logic [31:0] eng_data = 32'h0;
  int eng_cnt = 0, eng_lat = 3;
  logic [7:0] resp_q[$], log_num[$], log_crc[$];
  logic [31:0] log_arg[$];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  sd_init_ctrl #(.ACMD41_RETRIES(3), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .i_init_req(init_req), .o_init_done(o_init_done),
    .o_init_err(o_init_err), .o_err_code(o_err_code), .o_busy(o_busy),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_ack(o_rd_ack), .o_rd_data(o_rd_data),
    .o_cmd_number(o_cmd_number), .o_cmd_args(o_cmd_args), .o_cmd_crc(o_cmd_crc),
    .o_cmd_start(o_cmd_start), .i_cmd_done(eng_done), .i_cmd_resp_flags(eng_flags),
    .i_cmd_resp_data(eng_data)
  );
  // engine model: logs each start, drops done, answers from resp_q after eng_lat cycles
  always @(negedge clk) begin
    if (!reset) begin
      eng_done = 1'b1;
      eng_cnt  = 0;
    end else if (o_cmd_start) begin
      log_num.push_back(o_cmd_number);
      log_arg.push_back(o_cmd_args);
      log_crc.push_back(o_cmd_crc);
      if (!hang) begin eng_done = 1'b0; eng_cnt = eng_lat; end
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_flags = resp_q.size() > 0 ? resp_q.pop_front() : 8'hFF;
        eng_done  = 1'b1;
      end
    end
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic pulse(input logic ini, input logic rd);
    @(negedge clk); init_req = ini; rd_req = rd;
    @(negedge clk); init_req = 1'b0; rd_req = 1'b0;
  endtask
  task automatic settle(input string tag);
    int n = 0;
    while (!(o_init_done || o_init_err) && n < 2000) begin @(negedge clk); n++; end
    chk(tag, {31'b0, o_init_done || o_init_err}, 32'd1);
  endtask
  task automatic clear_logs;
    log_num.delete(); log_arg.delete(); log_crc.delete();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, acks;
    logic [31:0] got;
    repeat (3) @(negedge clk);
    chk("rst_init_done", o_init_done, 0);
    chk("rst_init_err", o_init_err, 0);
    chk("rst_err_code", o_err_code, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_cmd_start", o_cmd_start, 0);
    chk("rst_rd_ack", o_rd_ack, 0);
    chk("rst_rd_data", o_rd_data, 0);
    reset = 1'b1;
    // read request before initialisation must be dropped
    rd_addr = 32'h55;
    pulse(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("idle_rd_no_cmd", log_num.size(), 0);
    chk("idle_rd_busy", o_busy, 0);
    // successful init with two ACMD41 rounds
    eng_data = 32'h0;
    resp_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
`ifdef SD_CMD58_EN
    resp_q.push_back(8'h00);
`endif
    pulse(1'b1, 1'b0);
    settle("init_settle");
    chk("init_done", o_init_done, 1);
    chk("init_err_low", o_init_err, 0);
    chk("init_cmd_count", log_num.size(), N_INIT);
    chk("init_num0", log_num[0], 8'h40);
    chk("init_num1", log_num[1], 8'h48);
    chk("init_num2", log_num[2], 8'h77);
    chk("init_num3", log_num[3], 8'h69);
    chk("init_num5", log_num[5], 8'h69);
    chk("init_arg0", log_arg[0], 32'h0);
    chk("init_arg1", log_arg[1], 32'h1AA);
    chk("init_arg2", log_arg[2], 32'h0);
    chk("init_arg3", log_arg[3], 32'h4000_0000);
    chk("init_crc0", log_crc[0], 8'h95);
    chk("init_crc1", log_crc[1], 8'h87);
    chk("init_crc3", log_crc[3], 8'hFF);
    chk("ready_busy", o_busy, 0);
    // single block read
    clear_logs();
    resp_q.push_back(8'h00);
    eng_data = 32'hDEAD_BEEF;
    rd_addr  = 32'h10;
    pulse(1'b0, 1'b1);
    rd_addr = 32'h99;
    acks = 0; got = 32'h0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_rd_ack) begin acks++; got = o_rd_data; end
    end
    chk("rd_ack_count", acks, 1);
    chk("rd_data_at_ack", got, 32'hDEAD_BEEF);
    chk("rd_data_held", o_rd_data, 32'hDEAD_BEEF);
    chk("rd_num", log_num[0], 8'h51);
    chk("rd_arg", log_arg[0], EXP_RD_ARG);
    chk("rd_crc", log_crc[0], 8'hFF);
    chk("rd_back_ready", o_init_done, 1);
    // init_req beats rd_req; CMD0 answered 0xFF
    clear_logs();
    resp_q.push_back(8'hFF);
    pulse(1'b1, 1'b1);
    chk("restart_done_drops", o_init_done, 0);
    settle("cmd0_err_settle");
    chk("cmd0_err", o_init_err, 1);
    chk("cmd0_code", o_err_code, 1);
    chk("cmd0_first", log_num[0], 8'h40);
    repeat (30) @(negedge clk);
    chk("cmd0_no_more_start", log_num.size(), 1);
    pulse(1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("err_rd_ignored", log_num.size(), 1);
    chk("err_sticky", o_init_err, 1);
    // v1 card on CMD8, then ACMD41 never ready: three rounds then error 3
    clear_logs();
    resp_q = '{8'h01, 8'h05, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    pulse(1'b1, 1'b0);
    chk("restart_code_clear", o_err_code, 0);
    chk("restart_err_clear", o_init_err, 0);
    settle("retry_settle");
    chk("retry_code", o_err_code, 3);
    chk("retry_cmd_count", log_num.size(), 8);
    chk("retry_num6", log_num[6], 8'h77);
    chk("retry_num7", log_num[7], 8'h69);
    // engine never leaves idle: timeout 100 wait cycles after the start cycle
    clear_logs();
    hang = 1'b1;
    pulse(1'b1, 1'b0);
    n = 0;
    while (!o_cmd_start && n < 20) begin @(negedge clk); n++; end
    chk("to_start_seen", o_cmd_start, 1);
    @(negedge clk);
    chk("to_busy", o_busy, 1);
    n = 1;
    while (!o_init_err && n < 300) begin @(negedge clk); n++; end
    chk("to_cycles", n, 101);
    chk("to_code", o_err_code, 5);
    hang = 1'b0;
    // reset while ACMD41 waits for the engine
    clear_logs();
    eng_lat = 20;
    resp_q = '{8'h01, 8'h01, 8'h01};
    pulse(1'b1, 1'b0);
    n = 0;
    while (log_num.size() < 4 && n < 300) begin @(negedge clk); n++; end
    chk("mid_acmd41_issued", log_num[3], 8'h69);
    repeat (5) @(negedge clk);
    chk("mid_busy", o_busy, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_start", o_cmd_start, 0);
    chk("mid_rst_num", o_cmd_number, 0);
    chk("mid_rst_args", o_cmd_args, 0);
    chk("mid_rst_crc", o_cmd_crc, 0);
    chk("mid_rst_err", o_init_err, 0);
    chk("mid_rst_code", o_err_code, 0);
    chk("mid_rst_rd_data", o_rd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    resp_q.delete();
    clear_logs();
    eng_lat = 3;
    resp_q = '{8'h01, 8'h01, 8'h01, 8'h00};
`ifdef SD_CMD58_EN
    resp_q.push_back(8'h00);
`endif
    pulse(1'b1, 1'b0);
    settle("reinit_settle");
    chk("reinit_first_cmd0", log_num[0], 8'h40);
    chk("reinit_done", o_init_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_init_ctrl.md
Name: sd_init_ctrl

Overview:
Sequencer that drives the SPI-mode SD command engine through its start/done handshake. On request it runs the card power-up sequence CMD0, CMD8, then CMD55+ACMD41 until the card is ready. Afterwards it serves single-block read commands (CMD17) from a user port and returns the first 32 data bits captured by the engine. It sits between the system/host logic and the command engine, and owns every cmd_number/cmd_args/cmd_crc value the engine sees.

Parameters:
ACMD41_RETRIES, 1000, max CMD55+ACMD41 pairs before failing init
TIMEOUT_CYCLES, 65535, max cycles from cmd_start to engine completion per command

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
init_req  in  1  pulse: start (or restart) initialisation
init_done  out  1  high while card initialised and idle/serving reads
init_err  out  1  high in ERROR state
err_code  out  4  0 none, 1 CMD0, 2 CMD8, 3 ACMD41 retries exhausted, 4 CMD17, 5 timeout, 6 CMD58
busy  out  1  high whenever a command is outstanding
rd_req  in  1  pulse: read block at rd_addr
rd_addr  in  32  block address
rd_ack  out  1  one-cycle pulse, rd_data valid
rd_data  out  32  captured data word, held until next rd_ack
cmd_number  out  8  to engine, 0x40|index
cmd_args  out  32  to engine
cmd_crc  out  8  to engine
cmd_start  out  1  one-cycle start pulse to engine
cmd_done  in  1  engine idle flag (high when idle)
cmd_resp_flags  in  8  engine R1 response
cmd_resp_data  in  32  engine data word

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs 0; retry and timeout counters 0. Reset mid-command abandons it; cmd_start low next cycle.
- Command sub-handshake, shared by every command: ISSUE (cmd_* registered stable, cmd_start=1 for exactly 1 cycle) -> WAIT_BUSY (until cmd_done==0) -> WAIT_DONE (until cmd_done==1) -> CHECK (evaluate cmd_resp_flags). cmd_number/args/crc stay stable from ISSUE through CHECK.
- Timeout counter runs in WAIT_BUSY and WAIT_DONE. Reaching TIMEOUT_CYCLES -> ERROR, err_code=5.
- busy=1 from ISSUE through CHECK.
- Main FSM transitions:
  - IDLE --init_req--> CMD0.
  - CMD0: args 0, crc 0x95. Response 0x01 -> CMD8; else ERROR code 1.
  - CMD8: args 0x000001AA, crc 0x87. Response 0x01 -> CMD55; response 0x05 (v1 card) -> CMD55; else ERROR code 2.
  - CMD55: args 0, crc 0xFF. Response 0x00 or 0x01 -> ACMD41; else ERROR code 3.
  - ACMD41: cmd_number 0x69, args 0x40000000, crc 0xFF. Response 0x00 -> READY (or CMD58 if enabled). Response 0x01 -> retry++, back to CMD55. Retry reaching ACMD41_RETRIES -> ERROR code 3.
  - READY: init_done=1. rd_req -> CMD17; init_req -> CMD0 (init_done drops).
  - CMD17: cmd_number 0x51, args = rd_addr latched on rd_req, crc 0xFF. Response 0x00 -> rd_data<=cmd_resp_data, rd_ack=1 for one cycle, return to READY; else ERROR code 4.
  - ERROR: sticky; init_err=1. Only init_req leaves it (-> CMD0, err_code cleared).
- rd_req outside READY is ignored: no ack, not queued. init_req during an init sequence is ignored. init_req and rd_req both high in READY: init_req wins.
- Retry counter clears on entry to CMD0. Timeout counter clears at each ISSUE.

Optional Feature:
Macro SD_CMD58_EN.
- Defined: after ACMD41 returns 0x00, issue CMD58 (0x7A, args 0, crc 0xFF). Response 0x00 -> latch ccs=cmd_resp_data[30] and go to READY; else ERROR code 6. In CMD17, if ccs==0, cmd_args = rd_addr<<9 (byte addressing, upper bits dropped); if ccs==1, cmd_args = rd_addr.
- Undefined: no CMD58 state; cmd_args = rd_addr always.

Decomposition:
- Package sd_pkg holds: command-byte constants (CMD0 0x40, CMD8 0x48, CMD17 0x51, CMD55 0x77, ACMD41 0x69, CMD58 0x7A); CRC constants; R1 constants (R1_IDLE 0x01, R1_READY 0x00); err_code enum; main-state enum.
- One sub-module, sd_cmd_issue, implements ISSUE/WAIT_BUSY/WAIT_DONE plus the timeout counter and returns a done/timeout pulse to the main FSM.

Test Plan:
- Model responses 0x01, 0x01, 0x01, 0x01, 0x01, 0x00 (CMD0, CMD8, CMD55, ACMD41, CMD55, ACMD41) -> init_done=1 after exactly two ACMD41s; cmd_args observed 0, 0x1AA, 0, 0x40000000.
- CMD0 responds 0xFF -> init_err=1, err_code=1, no further cmd_start pulses.
- ACMD41 always 0x01 with ACMD41_RETRIES=3 -> exactly 3 CMD55/ACMD41 pairs, then err_code=3.
- Engine never drops cmd_done after start, TIMEOUT_CYCLES=100 -> err_code=5 at 100 cycles.
- In READY, rd_req with rd_addr=0x10, CMD17 response 0x00, data 0xDEADBEEF -> cmd_args 0x10 (0x2000 if SD_CMD58_EN with ccs=0), rd_ack one cycle, rd_data=0xDEADBEEF.
- reset low during WAIT_DONE of ACMD41 -> all outputs 0 next cycle; a later init_req restarts at CMD0.
